pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage core. Merges per-stage stall requests into the 6-bit stall vector consumed by the fetch unit and the pipeline registers. Sequences control-flow redirects from the decoder (jump/branch) and the exception unit. Produces a single registered-priority redirect with matching flush bits. Sits between idu/exu/lsu/excp and ifu plus all stage registers.

---
 rtl/pipe_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests, sequences jump and
// exception redirects, and generates per-stage stall/flush vectors.
module pipe_ctrl #(
   parameter int unsigned REG_W         = 32,
   parameter int unsigned DRAIN_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stallreq_if_i,
   input  logic             stallreq_id_i,
   input  logic             stallreq_ex_i,
   input  logic             stallreq_mem_i,
   input  logic             jump_req_i,
   input  logic [REG_W-1:0] jump_pc_i,
   input  logic             excp_req_i,
   input  logic [REG_W-1:0] excp_pc_i,
   input  logic             mem_busy_i,
   output logic [5:0]       stall_o,
   output logic [5:0]       flush_o,
   output logic             redirect_req_o,
   output logic [REG_W-1:0] redirect_pc_o,
   output logic             excp_ack_o,
   output logic             drain_timeout_o
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned VEC_W = 6;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_TRAP  = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic               r_pend_vld, w_pend_vld_nxt;
   logic [REG_W-1:0]   r_pend_pc, w_pend_pc_nxt;
   logic [REG_W-1:0]   r_excp_pc, w_excp_pc_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_timeout, w_timeout_nxt;

   logic [VEC_W-1:0]   w_stage_stall;
   logic [VEC_W-1:0]   w_stall;
   logic [VEC_W-1:0]   w_flush;
   logic               w_redir;
   logic [REG_W-1:0]   w_redir_pc;
   logic               w_ack;

   // Highest stalling stage freezes itself and everything upstream
   always_comb begin
      w_stage_stall = '0;
      if (stallreq_mem_i)     w_stage_stall = 6'b011111;
      else if (stallreq_ex_i) w_stage_stall = 6'b001111;
      else if (stallreq_id_i) w_stage_stall = 6'b000111;
      else if (stallreq_if_i) w_stage_stall = 6'b000011;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pend_vld <= 1'b0;
         r_pend_pc  <= '0;
         r_excp_pc  <= '0;
         r_cnt      <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pend_vld <= w_pend_vld_nxt;
         r_pend_pc  <= w_pend_pc_nxt;
         r_excp_pc  <= w_excp_pc_nxt;
         r_cnt      <= w_cnt_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pend_vld_nxt = r_pend_vld;
      w_pend_pc_nxt  = r_pend_pc;
      w_excp_pc_nxt  = r_excp_pc;
      w_cnt_nxt      = r_cnt;
      w_timeout_nxt  = r_timeout;
      w_stall        = '0;
      w_flush        = '0;
      w_redir        = 1'b0;
      w_redir_pc     = '0;
      w_ack          = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_stall = w_stage_stall;
            if (excp_req_i) begin
               // Exception wins over any same-cycle or pending jump
               w_excp_pc_nxt  = excp_pc_i;
               w_pend_vld_nxt = 1'b0;
               w_cnt_nxt      = '0;
               w_state_nxt    = mem_busy_i ? S_DRAIN : S_TRAP;
            end else if (!w_stall[0]) begin
               if (jump_req_i) begin
                  w_redir        = 1'b1;
                  w_redir_pc     = jump_pc_i;
                  w_flush[1]     = 1'b1;
                  w_pend_vld_nxt = 1'b0;
               end else if (r_pend_vld) begin
                  w_redir        = 1'b1;
                  w_redir_pc     = r_pend_pc;
                  w_flush[1]     = 1'b1;
                  w_pend_vld_nxt = 1'b0;
               end
            end else if (jump_req_i) begin
               w_pend_vld_nxt = 1'b1;
               w_pend_pc_nxt  = jump_pc_i;
            end
         end
         S_DRAIN: begin
            w_stall   = 6'b001111;
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (!mem_busy_i) begin
               w_state_nxt = S_TRAP;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt   = S_TRAP;
               w_timeout_nxt = 1'b1;
            end
         end
         S_TRAP: begin
            w_redir     = 1'b1;
            w_redir_pc  = r_excp_pc;
            w_flush     = 6'b011110;
            w_ack       = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // A frozen register feeding a running one must hand it a bubble
      for (int k = 1; k <= 3; k++) begin
         if (w_stall[k] && !w_stall[k+1]) w_flush[k+1] = 1'b1;
      end
   end

   assign stall_o         = rst_n ? w_stall : '0;
   assign flush_o         = rst_n ? w_flush : '0;
   assign redirect_req_o  = rst_n & w_redir;
   assign redirect_pc_o   = rst_n ? w_redir_pc : '0;
   assign excp_ack_o      = rst_n & w_ack;
   assign drain_timeout_o = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, jumps, exception drain/trap,
// drain timeout and reset abort.
module tb_pipe_ctrl;

   localparam int unsigned REG_W = 32;

   logic             clk;
   logic             rst_n;
   logic             stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
   logic             jump_req_i;
   logic [REG_W-1:0] jump_pc_i;
   logic             excp_req_i;
   logic [REG_W-1:0] excp_pc_i;
   logic             mem_busy_i;
   logic [5:0]       stall_o, flush_o;
   logic             redirect_req_o;
   logic [REG_W-1:0] redirect_pc_o;
   logic             excp_ack_o;
   logic             drain_timeout_o;

   int total = 0;
   int bad   = 0;

   pipe_ctrl #(.REG_W(REG_W), .DRAIN_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
      .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
      .jump_req_i(jump_req_i), .jump_pc_i(jump_pc_i),
      .excp_req_i(excp_req_i), .excp_pc_i(excp_pc_i),
      .mem_busy_i(mem_busy_i),
      .stall_o(stall_o), .flush_o(flush_o),
      .redirect_req_o(redirect_req_o), .redirect_pc_o(redirect_pc_o),
      .excp_ack_o(excp_ack_o), .drain_timeout_o(drain_timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      stallreq_if_i = 0; stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
      jump_req_i = 0; jump_pc_i = '0; excp_req_i = 0; excp_pc_i = '0; mem_busy_i = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      stallreq_mem_i = 1;
      jump_req_i = 1; jump_pc_i = 32'h80;
      #1;
      total++; if (stall_o !== 6'b0) begin bad++; $display("FAIL rst_stall got=%b exp=%b", stall_o, 6'b0); end
      total++; if (redirect_req_o !== 1'b0) begin bad++; $display("FAIL rst_redir got=%b exp=0", redirect_req_o); end
      total++; if (drain_timeout_o !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", drain_timeout_o); end
      repeat (2) @(negedge clk);
      rst_n = 1;
      clear_inputs();
      #1;
      total++; if (stall_o !== 6'b0 || flush_o !== 6'b0) begin bad++; $display("FAIL rst_idle stall=%b flush=%b exp=0/0", stall_o, flush_o); end
      total++; if (excp_ack_o !== 1'b0 || redirect_pc_o !== '0) begin bad++; $display("FAIL rst_idle_ack ack=%b pc=%h exp=0/0", excp_ack_o, redirect_pc_o); end
   endtask

   task automatic test_stall_priority();
      @(negedge clk); clear_inputs(); stallreq_id_i = 1; stallreq_mem_i = 1; #1;
      total++; if (stall_o !== 6'b011111 || flush_o !== 6'b000000) begin bad++; $display("FAIL prio_mem stall=%b flush=%b exp=011111/000000", stall_o, flush_o); end
      @(negedge clk); clear_inputs(); stallreq_id_i = 1; #1;
      total++; if (stall_o !== 6'b000111 || flush_o !== 6'b001000) begin bad++; $display("FAIL prio_id stall=%b flush=%b exp=000111/001000", stall_o, flush_o); end
      @(negedge clk); clear_inputs(); stallreq_if_i = 1; stallreq_ex_i = 1; #1;
      total++; if (stall_o !== 6'b001111 || flush_o !== 6'b010000) begin bad++; $display("FAIL prio_ex stall=%b flush=%b exp=001111/010000", stall_o, flush_o); end
      @(negedge clk); clear_inputs(); stallreq_if_i = 1; #1;
      total++; if (stall_o !== 6'b000011 || flush_o !== 6'b000100) begin bad++; $display("FAIL prio_if stall=%b flush=%b exp=000011/000100", stall_o, flush_o); end
      @(negedge clk); clear_inputs(); #1;
      total++; if (stall_o !== 6'b000000 || flush_o !== 6'b000000) begin bad++; $display("FAIL prio_none stall=%b flush=%b exp=0/0", stall_o, flush_o); end
   endtask

   task automatic test_jump_immediate();
      @(negedge clk); clear_inputs(); jump_req_i = 1; jump_pc_i = 32'h80; #1;
      total++; if (redirect_req_o !== 1'b1 || redirect_pc_o !== 32'h80) begin bad++; $display("FAIL jmp_imm req=%b pc=%h exp=1/80", redirect_req_o, redirect_pc_o); end
      total++; if (flush_o !== 6'b000010 || stall_o !== 6'b0) begin bad++; $display("FAIL jmp_imm_flush flush=%b stall=%b exp=000010/0", flush_o, stall_o); end
      @(negedge clk); clear_inputs(); #1;
      total++; if (redirect_req_o !== 1'b0 || redirect_pc_o !== '0) begin bad++; $display("FAIL jmp_imm_after req=%b pc=%h exp=0/0", redirect_req_o, redirect_pc_o); end
   endtask

   task automatic test_jump_deferred();
      @(negedge clk); clear_inputs(); stallreq_ex_i = 1; jump_req_i = 1; jump_pc_i = 32'h100; #1;
      total++; if (redirect_req_o !== 1'b0 || stall_o !== 6'b001111) begin bad++; $display("FAIL jmp_def_c1 req=%b stall=%b exp=0/001111", redirect_req_o, stall_o); end
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk); clear_inputs(); stallreq_ex_i = 1; #1;
         total++; if (redirect_req_o !== 1'b0) begin bad++; $display("FAIL jmp_def_hold%0d req=%b exp=0", c, redirect_req_o); end
      end
      @(negedge clk); clear_inputs(); #1;
      total++; if (redirect_req_o !== 1'b1 || redirect_pc_o !== 32'h100 || flush_o !== 6'b000010) begin bad++; $display("FAIL jmp_def_fire req=%b pc=%h flush=%b exp=1/100/000010", redirect_req_o, redirect_pc_o, flush_o); end
      @(negedge clk); clear_inputs(); #1;
      total++; if (redirect_req_o !== 1'b0) begin bad++; $display("FAIL jmp_def_once req=%b exp=0", redirect_req_o); end
      // pending target overwritten by a later jump
      @(negedge clk); clear_inputs(); stallreq_id_i = 1; jump_req_i = 1; jump_pc_i = 32'h11; #1;
      @(negedge clk); clear_inputs(); stallreq_id_i = 1; jump_req_i = 1; jump_pc_i = 32'h22; #1;
      @(negedge clk); clear_inputs(); #1;
      total++; if (redirect_req_o !== 1'b1 || redirect_pc_o !== 32'h22) begin bad++; $display("FAIL jmp_overwrite req=%b pc=%h exp=1/22", redirect_req_o, redirect_pc_o); end
   endtask

   task automatic test_excp_drain();
      @(negedge clk); clear_inputs(); excp_req_i = 1; excp_pc_i = 32'h200; mem_busy_i = 1; #1;
      total++; if (redirect_req_o !== 1'b0 || excp_ack_o !== 1'b0) begin bad++; $display("FAIL exd_entry req=%b ack=%b exp=0/0", redirect_req_o, excp_ack_o); end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk); mem_busy_i = (c < 3); stallreq_if_i = 1; #1;
         total++; if (stall_o !== 6'b001111 || excp_ack_o !== 1'b0 || redirect_req_o !== 1'b0) begin bad++; $display("FAIL exd_drain%0d stall=%b ack=%b req=%b exp=001111/0/0", c, stall_o, excp_ack_o, redirect_req_o); end
      end
      @(negedge clk); stallreq_if_i = 0; #1;
      total++; if (redirect_req_o !== 1'b1 || redirect_pc_o !== 32'h200) begin bad++; $display("FAIL exd_trap_redir req=%b pc=%h exp=1/200", redirect_req_o, redirect_pc_o); end
      total++; if (flush_o !== 6'b011110 || stall_o !== 6'b0 || excp_ack_o !== 1'b1) begin bad++; $display("FAIL exd_trap flush=%b stall=%b ack=%b exp=011110/0/1", flush_o, stall_o, excp_ack_o); end
      total++; if (drain_timeout_o !== 1'b0) begin bad++; $display("FAIL exd_no_timeout got=%b exp=0", drain_timeout_o); end
      @(negedge clk); clear_inputs(); #1;
      total++; if (excp_ack_o !== 1'b0 || redirect_req_o !== 1'b0 || stall_o !== 6'b0) begin bad++; $display("FAIL exd_idle ack=%b req=%b stall=%b exp=0/0/0", excp_ack_o, redirect_req_o, stall_o); end
   endtask

   task automatic test_excp_vs_jump();
      @(negedge clk); clear_inputs(); jump_req_i = 1; jump_pc_i = 32'h40; excp_req_i = 1; excp_pc_i = 32'h200; #1;
      total++; if (redirect_req_o !== 1'b0) begin bad++; $display("FAIL exj_same req=%b pc=%h exp=0", redirect_req_o, redirect_pc_o); end
      @(negedge clk); jump_req_i = 0; #1;
      total++; if (redirect_req_o !== 1'b1 || redirect_pc_o !== 32'h200 || excp_ack_o !== 1'b1) begin bad++; $display("FAIL exj_trap req=%b pc=%h ack=%b exp=1/200/1", redirect_req_o, redirect_pc_o, excp_ack_o); end
      @(negedge clk); clear_inputs(); #1;
      total++; if (redirect_req_o !== 1'b0) begin bad++; $display("FAIL exj_after req=%b pc=%h exp=0", redirect_req_o, redirect_pc_o); end
      // pending jump must be discarded by the exception
      @(negedge clk); clear_inputs(); stallreq_if_i = 1; jump_req_i = 1; jump_pc_i = 32'h40; #1;
      @(negedge clk); clear_inputs(); excp_req_i = 1; excp_pc_i = 32'h200; #1;
      total++; if (redirect_req_o !== 1'b0) begin bad++; $display("FAIL exj_pend_entry req=%b pc=%h exp=0", redirect_req_o, redirect_pc_o); end
      @(negedge clk); #1;
      total++; if (redirect_req_o !== 1'b1 || redirect_pc_o !== 32'h200) begin bad++; $display("FAIL exj_pend_trap req=%b pc=%h exp=1/200", redirect_req_o, redirect_pc_o); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); clear_inputs(); #1;
         total++; if (redirect_req_o !== 1'b0) begin bad++; $display("FAIL exj_pend_gone%0d req=%b pc=%h exp=0", c, redirect_req_o, redirect_pc_o); end
      end
   endtask

   task automatic test_timeout();
      @(negedge clk); clear_inputs(); excp_req_i = 1; excp_pc_i = 32'h300; mem_busy_i = 1; #1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk); #1;
         total++; if (stall_o !== 6'b001111 || excp_ack_o !== 1'b0 || drain_timeout_o !== 1'b0) begin bad++; $display("FAIL to_drain%0d stall=%b ack=%b to=%b exp=001111/0/0", c, stall_o, excp_ack_o, drain_timeout_o); end
      end
      @(negedge clk); #1;
      total++; if (excp_ack_o !== 1'b1 || redirect_pc_o !== 32'h300 || drain_timeout_o !== 1'b1) begin bad++; $display("FAIL to_trap ack=%b pc=%h to=%b exp=1/300/1", excp_ack_o, redirect_pc_o, drain_timeout_o); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); clear_inputs(); #1;
         total++; if (drain_timeout_o !== 1'b1 || excp_ack_o !== 1'b0) begin bad++; $display("FAIL to_sticky%0d to=%b ack=%b exp=1/0", c, drain_timeout_o, excp_ack_o); end
      end
   endtask

   task automatic test_reset_mid_drain();
      @(negedge clk); clear_inputs(); excp_req_i = 1; excp_pc_i = 32'h400; mem_busy_i = 1; #1;
      @(negedge clk); #2;
      rst_n = 0; stallreq_ex_i = 1; #1;
      total++; if (stall_o !== 6'b0 || flush_o !== 6'b0 || redirect_req_o !== 1'b0 || excp_ack_o !== 1'b0 || drain_timeout_o !== 1'b0) begin bad++; $display("FAIL rmd_low stall=%b flush=%b req=%b ack=%b to=%b exp=all0", stall_o, flush_o, redirect_req_o, excp_ack_o, drain_timeout_o); end
      @(negedge clk); rst_n = 1; clear_inputs(); stallreq_if_i = 1; #1;
      total++; if (stall_o !== 6'b000011 || excp_ack_o !== 1'b0 || redirect_req_o !== 1'b0) begin bad++; $display("FAIL rmd_idle stall=%b ack=%b req=%b exp=000011/0/0", stall_o, excp_ack_o, redirect_req_o); end
      @(negedge clk); clear_inputs(); #1;
      total++; if (excp_ack_o !== 1'b0 || redirect_req_o !== 1'b0 || stall_o !== 6'b0) begin bad++; $display("FAIL rmd_no_trap ack=%b req=%b stall=%b exp=0/0/0", excp_ack_o, redirect_req_o, stall_o); end
   endtask

   initial begin
      test_reset();
      test_stall_priority();
      test_jump_immediate();
      test_jump_deferred();
      test_excp_drain();
      test_excp_vs_jump();
      test_timeout();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
